// File: rtl/stream_reader_if.sv
// Handshake bundle between the serial bit source and stream_reader.
// The master drives the framed bit stream; the slave returns byte/error strobes and busy.
interface stream_reader_if;
    logic       in_frame;
    logic       in_valid;
    logic       in_bit;
    logic [7:0] input_byte_pulsed;
    logic       is_key_pulsed;
    logic       input_pulse;
    logic       err_pulse;
    logic       busy;

    modport master (
        output in_frame, in_valid, in_bit,
        input  input_byte_pulsed, is_key_pulsed, input_pulse, err_pulse, busy
    );

    modport slave (
        input  in_frame, in_valid, in_bit,
        output input_byte_pulsed, is_key_pulsed, input_pulse, err_pulse, busy
    );
endinterface

// File: rtl/stream_reader.sv
// Framed MSB-first serial deserializer emitting key/data-tagged byte strobes.
// Define STREAM_READER_PARITY_EN to require a trailing even-parity bit after every byte.
module stream_reader #(
    parameter int KEY_BYTES = 16
) (
    input  logic           clk,
    input  logic           rst,
    stream_reader_if.slave bus
);
`ifdef STREAM_READER_PARITY_EN
    localparam int SH_W = 8;
    localparam logic [3:0] LAST_BIT = 4'd8;
`else
    localparam int SH_W = 7;
    localparam logic [3:0] LAST_BIT = 4'd7;
`endif
    localparam logic [7:0] KEY_LIMIT = 8'(KEY_BYTES);

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, DISCARD} state_t;

    state_t            state, state_n;
    logic [SH_W-1:0]   shreg, shreg_n;
    logic [3:0]        bit_cnt, bit_cnt_n;
    logic [7:0]        byte_cnt, byte_cnt_n;
    logic              is_key, is_key_n;
    logic [7:0]        out_byte, out_byte_n;
    logic              out_key, out_key_n;
    logic              out_pulse, out_pulse_n;
    logic              out_err, out_err_n;
    logic [7:0]        cur_byte;
    logic              par_ok;
    logic              last;

`ifdef STREAM_READER_PARITY_EN
    // The shift register already holds the 8 data bits when the parity bit arrives.
    assign cur_byte = shreg;
    assign par_ok   = ~(^shreg ^ bus.in_bit);
`else
    assign cur_byte = {shreg, bus.in_bit};
    assign par_ok   = 1'b1;
`endif
    assign last = (bit_cnt == LAST_BIT);

    always_comb begin
        state_n     = state;
        shreg_n     = shreg;
        bit_cnt_n   = bit_cnt;
        byte_cnt_n  = byte_cnt;
        is_key_n    = is_key;
        out_byte_n  = 8'h00;
        out_key_n   = 1'b0;
        out_pulse_n = 1'b0;
        out_err_n   = 1'b0;

        if (state != IDLE && !bus.in_frame) begin
            // Frame end wins over any bit completing in the same cycle.
            state_n    = IDLE;
            out_err_n  = (state != DISCARD) && (bit_cnt != 4'd0);
            shreg_n    = '0;
            bit_cnt_n  = 4'd0;
            byte_cnt_n = 8'd0;
        end else begin
            if (state == IDLE && bus.in_frame)
                state_n = HEADER;
            if (bus.in_frame && bus.in_valid && state != DISCARD) begin
                if (!last) begin
                    shreg_n   = {shreg[SH_W-2:0], bus.in_bit};
                    bit_cnt_n = bit_cnt + 4'd1;
                end else begin
                    shreg_n   = '0;
                    bit_cnt_n = 4'd0;
                    if (!par_ok) begin
                        out_err_n = 1'b1;
                        state_n   = DISCARD;
                    end else if (state == HEADER) begin
                        if (cur_byte == 8'hA5) begin
                            state_n  = PAYLOAD;
                            is_key_n = 1'b1;
                        end else if (cur_byte == 8'h5A) begin
                            state_n  = PAYLOAD;
                            is_key_n = 1'b0;
                        end else begin
                            out_err_n = 1'b1;
                            state_n   = DISCARD;
                        end
                    end else if (is_key && byte_cnt == KEY_LIMIT) begin
                        out_err_n = 1'b1;
                        state_n   = DISCARD;
                    end else begin
                        out_pulse_n = 1'b1;
                        out_byte_n  = cur_byte;
                        out_key_n   = is_key;
                        if (byte_cnt != 8'hFF)
                            byte_cnt_n = byte_cnt + 8'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= 4'd0;
            byte_cnt  <= 8'd0;
            is_key    <= 1'b0;
            out_byte  <= 8'h00;
            out_key   <= 1'b0;
            out_pulse <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            bit_cnt   <= bit_cnt_n;
            byte_cnt  <= byte_cnt_n;
            is_key    <= is_key_n;
            out_byte  <= out_byte_n;
            out_key   <= out_key_n;
            out_pulse <= out_pulse_n;
            out_err   <= out_err_n;
        end
    end

    assign bus.input_byte_pulsed = out_byte;
    assign bus.is_key_pulsed     = out_key;
    assign bus.input_pulse       = out_pulse;
    assign bus.err_pulse         = out_err;
    assign bus.busy              = (state != IDLE);
endmodule

// File: tb/tb_stream_reader.sv
// Bench for stream_reader: random framed bit streams compared against a frame-level reference model.
`timescale 1ns/1ps
module tb_stream_reader;
    localparam int KB = 4;
`ifdef STREAM_READER_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    typedef struct packed {
        logic [31:0] cyc;
        logic        err;
        logic [7:0]  b;
        logic        key;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    stream_reader_if bus();

    stream_reader #(.KEY_BYTES(KB)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   viol = 0;
    ev_t  obs[$];
    ev_t  exp_q[$];
    bit   tx_bits[$];
    int   tx_cyc[$];
    int   drop_cyc;
    logic busy_at_drop, busy_after;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor: strobes captured mid-cycle with the cycle in which they were visible.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.input_pulse && bus.err_pulse) viol++;
            if (!bus.input_pulse && (bus.input_byte_pulsed !== 8'h00 || bus.is_key_pulsed !== 1'b0)) viol++;
            if (bus.input_pulse || bus.err_pulse)
                obs.push_back('{cyc, bus.err_pulse, bus.input_byte_pulsed, bus.is_key_pulsed});
        end
    end

    function automatic void add_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) tx_bits.push_back(b[i]);
    endfunction

    function automatic void add_byte(input logic [7:0] b);
        add_bits(b, 8);
`ifdef STREAM_READER_PARITY_EN
        tx_bits.push_back(^b);
`endif
    endfunction

    // Reference: split accepted bits into NB-bit groups and apply the frame rules directly.
    function automatic void build_expect();
        int  ng  = tx_bits.size() / NB;
        bit  stop = 0;
        bit  key = 0;
        int  cnt = 0;
        for (int g = 0; g < ng && !stop; g++) begin
            logic [7:0] v = 8'h00;
            int ones = 0;
            int t = tx_cyc[g*NB + NB - 1] + 1;
            for (int k = 0; k < 8; k++) v = {v[6:0], tx_bits[g*NB + k]};
            for (int k = 0; k < NB; k++) ones += int'(tx_bits[g*NB + k]);
            if (NB == 9 && (ones % 2) == 1) begin
                exp_q.push_back('{t, 1'b1, 8'h00, 1'b0}); stop = 1;
            end else if (g == 0) begin
                if (v == 8'hA5) key = 1;
                else if (v == 8'h5A) key = 0;
                else begin exp_q.push_back('{t, 1'b1, 8'h00, 1'b0}); stop = 1; end
            end else if (key && cnt == KB) begin
                exp_q.push_back('{t, 1'b1, 8'h00, 1'b0}); stop = 1;
            end else begin
                exp_q.push_back('{t, 1'b0, v, key}); cnt++;
            end
        end
        if (!stop && (tx_bits.size() % NB) != 0)
            exp_q.push_back('{drop_cyc + 1, 1'b1, 8'h00, 1'b0});
    endfunction

    // gap_mode: 0 continuous, 1 idle cycle after every bit, 2 random idle cycles.
    task automatic drive_frame(input int gap_mode);
        int gaps;
        tx_cyc.delete();
        @(posedge clk); #1;
        bus.in_frame = 1'b1;
        foreach (tx_bits[i]) begin
            gaps = 0;
            if (gap_mode == 2 && $urandom_range(99) < 30) gaps = int'($urandom_range(2, 1));
            repeat (gaps) begin bus.in_valid = 1'b0; @(posedge clk); #1; end
            bus.in_valid = 1'b1;
            bus.in_bit   = tx_bits[i];
            tx_cyc.push_back(cyc);
            @(posedge clk); #1;
            if (gap_mode == 1) begin bus.in_valid = 1'b0; @(posedge clk); #1; end
        end
        busy_at_drop = bus.busy;
        bus.in_frame = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_bit   = 1'b0;
        drop_cyc     = cyc;
        repeat (3) @(posedge clk);
        #1;
        busy_after = bus.busy;
        build_expect();
    endtask

    task automatic test_reset();
        bus.in_frame = 1'b0; bus.in_valid = 1'b0; bus.in_bit = 1'b0;
        rst = 1'b1;
        #2;
        n_chk++;
        if ({bus.input_pulse, bus.err_pulse, bus.input_byte_pulsed, bus.is_key_pulsed, bus.busy} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 000",
                     {bus.input_pulse, bus.err_pulse, bus.input_byte_pulsed, bus.is_key_pulsed, bus.busy});
        end
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b required 0", bus.busy); end
    endtask

    task automatic test_key_frame();
        obs.delete(); exp_q.delete(); tx_bits.delete();
        add_byte(8'hA5); add_byte(8'h01); add_byte(8'h02); add_byte(8'h03);
        drive_frame(0);
        n_chk++;
        if (obs.size() !== exp_q.size()) begin n_fail++; $display("FAIL key_frame_count: got %0d required %0d", obs.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs.size()) begin
            n_chk++;
            if (obs[i] !== exp_q[i]) begin n_fail++; $display("FAIL key_frame_ev%0d: got %h required %h", i, obs[i], exp_q[i]); end
        end
    endtask

    task automatic test_data_gaps();
        obs.delete(); exp_q.delete(); tx_bits.delete();
        add_byte(8'h5A); add_byte(8'hC3);
        drive_frame(1);
        n_chk++;
        if (obs.size() !== exp_q.size()) begin n_fail++; $display("FAIL data_gaps_count: got %0d required %0d", obs.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs.size()) begin
            n_chk++;
            if (obs[i] !== exp_q[i]) begin n_fail++; $display("FAIL data_gaps_ev%0d: got %h required %h", i, obs[i], exp_q[i]); end
        end
    endtask

    task automatic test_bad_header();
        obs.delete(); exp_q.delete(); tx_bits.delete();
        add_byte(8'h3C); add_byte(8'h11); add_byte(8'h22);
        drive_frame(0);
        n_chk++;
        if (busy_at_drop !== 1'b1) begin n_fail++; $display("FAIL bad_header_busy_in_frame: got %b required 1", busy_at_drop); end
        n_chk++;
        if (busy_after !== 1'b0) begin n_fail++; $display("FAIL bad_header_busy_after: got %b required 0", busy_after); end
        n_chk++;
        if (obs.size() !== exp_q.size()) begin n_fail++; $display("FAIL bad_header_count: got %0d required %0d", obs.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs.size()) begin
            n_chk++;
            if (obs[i] !== exp_q[i]) begin n_fail++; $display("FAIL bad_header_ev%0d: got %h required %h", i, obs[i], exp_q[i]); end
        end
    endtask

    task automatic test_key_overflow();
        obs.delete(); exp_q.delete(); tx_bits.delete();
        add_byte(8'hA5);
        for (int i = 1; i <= KB + 1; i++) add_byte(8'(i * 17));
        drive_frame(0);
        n_chk++;
        if (obs.size() !== exp_q.size()) begin n_fail++; $display("FAIL key_overflow_count: got %0d required %0d", obs.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs.size()) begin
            n_chk++;
            if (obs[i] !== exp_q[i]) begin n_fail++; $display("FAIL key_overflow_ev%0d: got %h required %h", i, obs[i], exp_q[i]); end
        end
    endtask

    task automatic test_partial_drop();
        obs.delete(); exp_q.delete(); tx_bits.delete();
        add_byte(8'h5A); add_byte(8'h77); add_bits(8'hE8, 5);
        drive_frame(0);
        tx_bits.delete();
        add_byte(8'hA5); add_byte(8'h11);
        drive_frame(0);
        n_chk++;
        if (obs.size() !== exp_q.size()) begin n_fail++; $display("FAIL partial_drop_count: got %0d required %0d", obs.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs.size()) begin
            n_chk++;
            if (obs[i] !== exp_q[i]) begin n_fail++; $display("FAIL partial_drop_ev%0d: got %h required %h", i, obs[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int r;
        logic [7:0] h;
        obs.delete(); exp_q.delete();
        for (int f = 0; f < 8; f++) begin
            tx_bits.delete();
            r = int'($urandom_range(9));
            h = (r < 4) ? 8'hA5 : (r < 8) ? 8'h5A : 8'($urandom_range(255));
            add_byte(h);
            for (int i = 0, n = int'($urandom_range(6)); i < n; i++) add_byte(8'($urandom_range(255)));
            if ($urandom_range(3) == 0) add_bits(8'($urandom_range(255)), int'($urandom_range(7, 1)));
            drive_frame(2);
        end
        n_chk++;
        if (obs.size() !== exp_q.size()) begin n_fail++; $display("FAIL back_to_back_count: got %0d required %0d", obs.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs.size()) begin
            n_chk++;
            if (obs[i] !== exp_q[i]) begin n_fail++; $display("FAIL back_to_back_ev%0d: got %h required %h", i, obs[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        ev_t e;
        obs.delete(); tx_bits.delete(); tx_cyc.delete();
        add_byte(8'hA5); add_byte(8'h01); add_bits(8'hF0, 4);
        @(posedge clk); #1;
        bus.in_frame = 1'b1;
        foreach (tx_bits[i]) begin
            bus.in_valid = 1'b1; bus.in_bit = tx_bits[i]; tx_cyc.push_back(cyc);
            @(posedge clk); #1;
        end
        n_chk++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL reset_mid_busy_before: got %b required 1", bus.busy); end
        @(negedge clk); rst = 1'b1; #1;
        n_chk++;
        if ({bus.input_pulse, bus.err_pulse, bus.input_byte_pulsed, bus.is_key_pulsed, bus.busy} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got %h required 000",
                     {bus.input_pulse, bus.err_pulse, bus.input_byte_pulsed, bus.is_key_pulsed, bus.busy});
        end
        bus.in_frame = 1'b0; bus.in_valid = 1'b0; bus.in_bit = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        e = '{tx_cyc[2*NB - 1] + 1, 1'b0, 8'h01, 1'b1};
        n_chk++;
        if (obs.size() !== 1) begin n_fail++; $display("FAIL reset_mid_count: got %0d required 1", obs.size()); end
        else begin
            n_chk++;
            if (obs[0] !== e) begin n_fail++; $display("FAIL reset_mid_ev0: got %h required %h", obs[0], e); end
        end
    endtask

`ifdef STREAM_READER_PARITY_EN
    task automatic test_parity();
        obs.delete(); exp_q.delete(); tx_bits.delete();
        add_byte(8'hA5); add_bits(8'h7E, 8); tx_bits.push_back(1'b1); add_byte(8'h01);
        drive_frame(0);
        n_chk++;
        if (obs.size() !== exp_q.size()) begin n_fail++; $display("FAIL parity_count: got %0d required %0d", obs.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs.size()) begin
            n_chk++;
            if (obs[i] !== exp_q[i]) begin n_fail++; $display("FAIL parity_ev%0d: got %h required %h", i, obs[i], exp_q[i]); end
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_key_frame();
        test_data_gaps();
        test_bad_header();
        test_key_overflow();
        test_partial_drop();
        test_back_to_back();
        test_reset_mid();
`ifdef STREAM_READER_PARITY_EN
        test_parity();
`endif
        n_chk++;
        if (viol !== 0) begin n_fail++; $display("FAIL strobe_rules: got %0d violations required 0", viol); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
